mt_regfile: RTL

//  Banked register file for all hardware threads: NUM_TRD x NUM_REG x DATA_W, two registered read

---
 rtl/mt_regfile.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mt_regfile.sv
`default_nettype none
// mt_regfile: NUM_TRD x NUM_REG banked register file, 2 registered read ports, 1 write port with
// same-cycle bypass and a one-register-per-cycle thread clear sequence. Optional macro:
// REGFILE_SCOREBOARD_EN (per-register pending bits). Revision: 1.0
module mt_regfile #(
  parameter int                NUM_TRD    = 8,
  parameter int                NUM_REG    = 32,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] ESP_BASE   = 32'h0001_0000,
  parameter logic [DATA_W-1:0] ESP_STRIDE = 32'h0000_2000,
  localparam int               TW         = $clog2(NUM_TRD),
  localparam int               RW         = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TW-1:0]     rd_trd,
  input  logic [RW-1:0]     reg_rd_a,
  input  logic [RW-1:0]     reg_rd_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              wr_en,
  input  logic [TW-1:0]     wr_trd,
  input  logic [RW-1:0]     reg_wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_req,
  input  logic [TW-1:0]     new_trd,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_busy,
  output logic              init_done,
  output logic              wr_drop,
  input  logic              alloc_en,
  input  logic [TW-1:0]     alloc_trd,
  input  logic [RW-1:0]     alloc_reg,
  output logic              pend_a,
  output logic              pend_b
);

  localparam logic [RW-1:0] FIRST_CLR = RW'(5);
  localparam logic [RW-1:0] LAST_REG  = RW'(NUM_REG - 1);
  localparam logic [RW-1:0] FIRST_RW  = RW'(2);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] esp(input logic [TW-1:0] t);
    return ESP_BASE - (DATA_W'(t) * ESP_STRIDE);
  endfunction

  function automatic logic [DATA_W-1:0] reset_val(input int t, input int r);
    if (r == 1) return DATA_W'(t);
    if (r == 2 || r == 3) return esp(TW'(t));
    return '0;
  endfunction

  state_t              state_q, state_d;
  logic [RW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]       trd_q, trd_d;
  logic                init_done_q, init_done_d;
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic [DATA_W-1:0]   mem_q   [NUM_TRD][NUM_REG];
  logic [DATA_W-1:0]   mem_d   [NUM_TRD][NUM_REG];
  logic [DATA_W-1:0]   mem_rst [NUM_TRD][NUM_REG];

  logic busy, accept, wr_valid, wr_conflict, wr_ok;
  logic byp_a, byp_b, mask_a, mask_b;

  for (genvar t = 0; t < NUM_TRD; t++) begin : g_rst_trd
    for (genvar r = 0; r < NUM_REG; r++) begin : g_rst_reg
      assign mem_rst[t][r] = reset_val(t, r);
    end
  end

  assign busy        = (state_q == ST_CLEAR);
  assign accept      = (state_q == ST_IDLE) && init_req;
  assign wr_valid    = wr_en && (reg_wr >= FIRST_RW);
  // Any write aimed at the thread being (re)initialised is lost, including in the accept cycle.
  assign wr_conflict = (busy && (wr_trd == trd_q)) || (accept && (wr_trd == new_trd));
  assign wr_ok       = wr_valid && !wr_conflict;
  assign wr_drop_d   = wr_valid && wr_conflict;

  assign byp_a  = wr_ok && (wr_trd == rd_trd) && (reg_wr == reg_rd_a);
  assign byp_b  = wr_ok && (wr_trd == rd_trd) && (reg_wr == reg_rd_b);
  assign mask_a = busy && (rd_trd == trd_q) && (reg_rd_a >= ptr_q);
  assign mask_b = busy && (rd_trd == trd_q) && (reg_rd_b >= ptr_q);

  always_comb begin
    data_a_d = byp_a ? wr_data : (mask_a ? '0 : mem_q[rd_trd][reg_rd_a]);
    data_b_d = byp_b ? wr_data : (mask_b ? '0 : mem_q[rd_trd][reg_rd_b]);
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_trd][reg_wr] = wr_data;
    if (accept) begin
      mem_d[new_trd][0] = '0;
      mem_d[new_trd][1] = DATA_W'(new_trd);
      mem_d[new_trd][2] = esp(new_trd);
      mem_d[new_trd][3] = esp(new_trd);
      mem_d[new_trd][4] = init_data;
    end
    if (busy) mem_d[trd_q][ptr_q] = '0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    trd_d       = trd_q;
    init_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_CLEAR;
          ptr_d   = FIRST_CLR;
          trd_d   = new_trd;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_REG) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      trd_q       <= '0;
      init_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      mem_q       <= mem_rst;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      trd_q       <= trd_d;
      init_done_q <= init_done_d;
      wr_drop_q   <= wr_drop_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      mem_q       <= mem_d;
    end
  end

  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign init_busy = busy;
  assign init_done = init_done_q;
  assign wr_drop   = wr_drop_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REG-1:0] pend_q [NUM_TRD];
  logic [NUM_REG-1:0] pend_d [NUM_TRD];
  logic               pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic               alloc_ok, alloc_hit_a, alloc_hit_b;

  assign alloc_ok    = alloc_en && (alloc_reg >= FIRST_RW) && !(busy && (alloc_trd == trd_q));
  assign alloc_hit_a = alloc_ok && (alloc_trd == rd_trd) && (alloc_reg == reg_rd_a);
  assign alloc_hit_b = alloc_ok && (alloc_trd == rd_trd) && (alloc_reg == reg_rd_b);

  always_comb begin
    pend_d = pend_q;
    // Alloc is applied after the write clear so a same-cycle alloc keeps the bit set.
    if (wr_ok) pend_d[wr_trd][reg_wr] = 1'b0;
    if (alloc_ok) pend_d[alloc_trd][alloc_reg] = 1'b1;
    if (accept) pend_d[new_trd] = '0;
    pend_a_d = byp_a ? alloc_hit_a : pend_q[rd_trd][reg_rd_a];
    pend_b_d = byp_b ? alloc_hit_b : pend_q[rd_trd][reg_rd_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '{default: '0};
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign pend_a = pend_a_q;
  assign pend_b = pend_b_q;
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc_en, alloc_trd, alloc_reg};
  assign pend_a       = 1'b0;
  assign pend_b       = 1'b0;
`endif

endmodule
`default_nettype wire
